// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath (lw, sw, addi, add, sub, and, or, beq).
// Optional feature: define ILLEGAL_TRAP_EN to park illegal instructions in a sticky TRAP state.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        zero,
  output logic        pc_write,
  output logic        ior_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_source,
  output logic [3:0]  alu_control,
  output logic [3:0]  state,
  output logic        instr_retire,
  output logic        illegal_inst
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    TRAP      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t     st;
  logic [6:0] opcode;
  logic [3:0] funct;
  logic       r_ok, dec_illegal;
  logic [3:0] r_alu;
  logic       pcw_u, pcw_c, mr_i, mw_i, irw_i, rw_i, ret_i, ill_i;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign funct       = {inst[14:12], inst[30]};
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};
  assign state       = st;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      4'b0000: r_alu = ALU_ADD;
      4'b0001: r_alu = ALU_SUB;
      4'b1110: r_alu = ALU_AND;
      4'b1100: r_alu = ALU_OR;
      default: r_ok  = 1'b0;
    endcase
    case (opcode)
      OP_LW, OP_SW, OP_I, OP_B: dec_illegal = 1'b0;
      OP_R:                     dec_illegal = !r_ok;
      default:                  dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else begin
      case (st)
        FETCH:    st <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: st <= MEM_ADDR;
            OP_R:         st <= R_EXEC;
            OP_I:         st <= I_EXEC;
            OP_B:         st <= BRANCH;
            default:      st <= FETCH;
          endcase
`ifdef ILLEGAL_TRAP_EN
          if (dec_illegal) st <= TRAP;
`else
          if (dec_illegal) st <= FETCH;
`endif
        end
        MEM_ADDR: st <= opcode[5] ? MEM_WRITE : MEM_READ;
        MEM_READ: st <= MEM_WB;
        R_EXEC:   st <= R_WB;
        I_EXEC:   st <= I_WB;
`ifdef ILLEGAL_TRAP_EN
        TRAP:     st <= TRAP;
`endif
        default:  st <= FETCH;
      endcase
    end
  end

  // Moore decode; only pc_write looks at zero, and only through pcw_c (BRANCH).
  always_comb begin
    pcw_u = 1'b0; pcw_c = 1'b0; mr_i = 1'b0; mw_i = 1'b0; irw_i = 1'b0;
    rw_i = 1'b0; ret_i = 1'b0; ill_i = 1'b0;
    ior_d = 1'b0; mem_to_reg = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00;
    pc_source = 1'b0; alu_control = ALU_ADD;
    case (st)
      FETCH:     begin mr_i = 1'b1; irw_i = 1'b1; alu_src_b = 2'b01; pcw_u = 1'b1; end
      DECODE: begin
        alu_src_b = 2'b10;
`ifndef ILLEGAL_TRAP_EN
        ret_i = dec_illegal;
`endif
      end
      MEM_ADDR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      MEM_READ:  begin mr_i = 1'b1; ior_d = 1'b1; end
      MEM_WB:    begin rw_i = 1'b1; mem_to_reg = 1'b1; ret_i = 1'b1; end
      MEM_WRITE: begin mw_i = 1'b1; ior_d = 1'b1; ret_i = 1'b1; end
      R_EXEC:    begin alu_src_a = 1'b1; alu_control = r_alu; end
      R_WB:      begin rw_i = 1'b1; ret_i = 1'b1; end
      I_EXEC:    begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      I_WB:      begin rw_i = 1'b1; ret_i = 1'b1; end
      BRANCH: begin
        alu_src_a = 1'b1; alu_control = ALU_SUB; pcw_c = 1'b1; pc_source = 1'b1; ret_i = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP:      ill_i = 1'b1;
`endif
      default: ;
    endcase
  end

  // Reset masks every write/strobe combinationally so a mid-instruction reset cycle is inert.
  assign pc_write     = !reset && (pcw_u || (pcw_c && zero));
  assign mem_read     = !reset && mr_i;
  assign mem_write    = !reset && mw_i;
  assign ir_write     = !reset && irw_i;
  assign reg_write    = !reset && rw_i;
  assign instr_retire = !reset && ret_i;
  assign illegal_inst = !reset && ill_i;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control; honours ILLEGAL_TRAP_EN if defined.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        zero;
  logic        pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_source;
  logic [3:0]  alu_control, state;
  logic        instr_retire, illegal_inst;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .inst(inst), .zero(zero),
    .pc_write(pc_write), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_control(alu_control), .state(state), .instr_retire(instr_retire),
    .illegal_inst(illegal_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] ins;
    logic        z;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[80];
  int   nv = 0;

  localparam logic [31:0] ADDI = 32'h01400193;
  localparam logic [31:0] LW   = 32'h0781A403;
  localparam logic [31:0] SW   = 32'h0081A223;
  localparam logic [31:0] SUB  = 32'h408505B3;
  localparam logic [31:0] ADD  = 32'h00340533;
  localparam logic [31:0] AND  = 32'h003476B3;
  localparam logic [31:0] OR   = 32'h00346733;
  localparam logic [31:0] BEQ  = 32'h00B18463;
  localparam logic [31:0] BAD  = 32'h00000000;

  // {state, pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
  //  alu_src_a, alu_src_b, pc_source, alu_control, instr_retire, illegal_inst}
  function automatic logic [20:0] o(input logic [3:0] st, input logic pcw, iord, mr, mw, irw,
                                    m2r, rw, a, input logic [1:0] b, input logic ps,
                                    input logic [3:0] ac, input logic ret, ill);
    return {st, pcw, iord, mr, mw, irw, m2r, rw, a, b, ps, ac, ret, ill};
  endfunction

  function automatic logic [20:0] actual();
    return {state, pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, pc_source, alu_control, instr_retire, illegal_inst};
  endfunction

  logic [20:0] E_RST, E_F, E_D, E_D_ILL, E_MA, E_MR, E_MWB, E_MW, E_RWB, E_IE, E_IWB;
  logic [20:0] E_B1, E_B0, E_TRAP;

  task automatic add(input string nm, input logic r, input logic [31:0] i, input logic z,
                     input logic [20:0] e);
    vecs[nv] = '{nm, r, i, z, e};
    nv++;
  endtask

  task automatic rexec(input string nm, input logic [3:0] ac);
    add({nm, "_f"}, 0, 32'h0, 0, E_F);
  endtask

  // Drive at the falling edge, sample 1 time unit later, well clear of the rising edge.
  task automatic step(input string nm, input logic r, input logic [31:0] i, input logic z,
                      input logic [20:0] e);
    logic [20:0] a;
    @(negedge clk);
    reset = r; inst = i; zero = z;
    #1;
    a = actual();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic instr(input string nm, input logic [31:0] i, input logic [20:0] last_exec,
                       input logic [20:0] wb);
    add({nm, "_fetch"}, 0, i, 0, E_F);
    add({nm, "_decode"}, 0, i, 0, E_D);
    add({nm, "_exec"}, 0, i, 0, last_exec);
    add({nm, "_wb"}, 0, i, 0, wb);
  endtask

  initial begin
    E_RST   = o(4'd0, 0,0,0,0,0,0,0, 0,2'b01,0,4'b0010, 0,0);
    E_F     = o(4'd0, 1,0,1,0,1,0,0, 0,2'b01,0,4'b0010, 0,0);
    E_D     = o(4'd1, 0,0,0,0,0,0,0, 0,2'b10,0,4'b0010, 0,0);
    E_D_ILL = o(4'd1, 0,0,0,0,0,0,0, 0,2'b10,0,4'b0010, 1,0);
    E_MA    = o(4'd2, 0,0,0,0,0,0,0, 1,2'b10,0,4'b0010, 0,0);
    E_MR    = o(4'd3, 0,1,1,0,0,0,0, 0,2'b00,0,4'b0010, 0,0);
    E_MWB   = o(4'd4, 0,0,0,0,0,1,1, 0,2'b00,0,4'b0010, 1,0);
    E_MW    = o(4'd5, 0,1,0,1,0,0,0, 0,2'b00,0,4'b0010, 1,0);
    E_RWB   = o(4'd7, 0,0,0,0,0,0,1, 0,2'b00,0,4'b0010, 1,0);
    E_IE    = o(4'd9, 0,0,0,0,0,0,0, 1,2'b10,0,4'b0010, 0,0);
    E_IWB   = o(4'd10,0,0,0,0,0,0,1, 0,2'b00,0,4'b0010, 1,0);
    E_B1    = o(4'd8, 1,0,0,0,0,0,0, 1,2'b00,1,4'b0110, 1,0);
    E_B0    = o(4'd8, 0,0,0,0,0,0,0, 1,2'b00,1,4'b0110, 1,0);
    E_TRAP  = o(4'd11,0,0,0,0,0,0,0, 0,2'b00,0,4'b0010, 0,1);

    for (int k = 0; k < 3; k++) add("reset_hold", 1, ADDI, 0, E_RST);
    instr("addi", ADDI, E_IE, E_IWB);
    add("lw_fetch", 0, LW, 0, E_F);
    add("lw_decode", 0, LW, 0, E_D);
    add("lw_addr", 0, LW, 0, E_MA);
    add("lw_read", 0, LW, 0, E_MR);
    add("lw_wb", 0, LW, 0, E_MWB);
    add("sw_fetch", 0, SW, 0, E_F);
    add("sw_decode", 0, SW, 0, E_D);
    add("sw_addr", 0, SW, 0, E_MA);
    add("sw_write", 0, SW, 0, E_MW);
    instr("sub", SUB, o(4'd6,0,0,0,0,0,0,0,1,2'b00,0,4'b0110,0,0), E_RWB);
    instr("add", ADD, o(4'd6,0,0,0,0,0,0,0,1,2'b00,0,4'b0010,0,0), E_RWB);
    instr("and", AND, o(4'd6,0,0,0,0,0,0,0,1,2'b00,0,4'b0000,0,0), E_RWB);
    instr("or",  OR,  o(4'd6,0,0,0,0,0,0,0,1,2'b00,0,4'b0001,0,0), E_RWB);
    add("beq1_fetch", 0, BEQ, 1, E_F);
    add("beq1_decode_zero_ignored", 0, BEQ, 1, E_D);
    add("beq1_taken", 0, BEQ, 1, E_B1);
    add("beq0_fetch", 0, BEQ, 0, E_F);
    add("beq0_decode", 0, BEQ, 1, E_D);
    add("beq0_not_taken", 0, BEQ, 0, E_B0);

    reset = 1'b1; inst = ADDI; zero = 1'b0;
    @(posedge clk);

    for (int k = 0; k < nv; k++)
      step(vecs[k].name, vecs[k].rst, vecs[k].ins, vecs[k].z, vecs[k].exp);

    // Illegal instruction (opcode 0) after decode.
    step("bad_fetch", 0, BAD, 0, E_F);
`ifdef ILLEGAL_TRAP_EN
    step("bad_decode", 0, BAD, 0, E_D);
    for (int k = 0; k < 10; k++) step("trap_hold", 0, BAD, 1, E_TRAP);
    step("trap_reset", 1, BAD, 0, o(4'd11,0,0,0,0,0,0,0,0,2'b00,0,4'b0010,0,0));
`else
    step("bad_decode_nop", 0, BAD, 0, E_D_ILL);
`endif
    step("after_bad_fetch", 0, ADDI, 0, E_F);
    step("after_bad_decode", 0, ADDI, 0, E_D);
    step("after_bad_iexec", 0, ADDI, 0, E_IE);
    step("after_bad_iwb", 0, ADDI, 0, E_IWB);

    // Reset pulsed while a load sits in MEM_READ: no writes, then a clean addi.
    step("mid_fetch", 0, LW, 0, E_F);
    step("mid_decode", 0, LW, 0, E_D);
    step("mid_addr", 0, LW, 0, E_MA);
    step("mid_read_reset", 1, LW, 0, o(4'd3,0,1,0,0,0,0,0,0,2'b00,0,4'b0010,0,0));
    step("mid_refetch", 0, ADDI, 0, E_F);
    step("mid_decode2", 0, ADDI, 0, E_D);
    step("mid_iexec", 0, ADDI, 0, E_IE);
    step("mid_iwb", 0, ADDI, 0, E_IWB);
    step("mid_next_fetch", 0, ADDI, 0, E_F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
